// File: rtl/intersection_controller.sv
// Two-road intersection lamp sequencer with a pedestrian crossing over the main road.
// Moore FSM with a single down-counter timer; outputs decode only registered state.
module intersection_controller #(
  parameter int MAIN_GREEN_MIN = 8,
  parameter int SIDE_GREEN     = 6,
  parameter int YELLOW         = 3,
  parameter int ALL_RED        = 2,
  parameter int CNT_W          = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       side_sensor_i,
  input  logic       ped_req_i,
  output logic [2:0] main_light_o,
  output logic [2:0] side_light_o,
  output logic       ped_walk_o,
  output logic       ped_pending_o,
  output logic [2:0] phase_o
);

  // state  | meaning
  // MAIN_G | main green, side red (rests here without demand)
  // MAIN_Y | main yellow, side red
  // CLR_A  | all red before side green
  // SIDE_G | main red, side green, walk may be active
  // SIDE_Y | main red, side yellow
  // CLR_B  | all red before main green (reset state)
  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    CLR_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    CLR_B  = 3'd5
  } state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_G = 3'b010;
  localparam logic [2:0] LAMP_Y = 3'b001;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, load_val;
  logic             walk_q, walk_d;
  logic             pend_q, pend_d;
  logic             tc;

  assign tc = (timer_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLR_B;
      timer_q <= CNT_W'(ALL_RED - 1);
      walk_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      walk_q  <= walk_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_G:  if (tc && (side_sensor_i || pend_q)) state_d = MAIN_Y;
      MAIN_Y:  if (tc) state_d = CLR_A;
      CLR_A:   if (tc) state_d = SIDE_G;
      SIDE_G:  if (tc) state_d = SIDE_Y;
      SIDE_Y:  if (tc) state_d = CLR_B;
      CLR_B:   if (tc) state_d = MAIN_G;
      default: state_d = CLR_B;
    endcase
  end

  always_comb begin
    load_val = CNT_W'(ALL_RED - 1);
    case (state_d)
      MAIN_G:         load_val = CNT_W'(MAIN_GREEN_MIN - 1);
      MAIN_Y, SIDE_Y: load_val = CNT_W'(YELLOW - 1);
      SIDE_G:         load_val = CNT_W'(SIDE_GREEN - 1);
      default:        load_val = CNT_W'(ALL_RED - 1);
    endcase
  end

  // Illegal codes always differ from CLR_B, so they take the reload path too.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)  timer_d = load_val;
    else if (!tc)            timer_d = timer_q - CNT_W'(1);
  end

  // Entering SIDE_G consumes the request, including one arriving that same cycle.
  always_comb begin
    pend_d = pend_q | ped_req_i;
    walk_d = walk_q;
    if (state_d == SIDE_G && state_q != SIDE_G) begin
      walk_d = pend_q | ped_req_i;
      pend_d = 1'b0;
    end else if (state_q == SIDE_G && state_d != SIDE_G) begin
      walk_d = 1'b0;
    end
  end

  always_comb begin
    main_light_o = LAMP_R;
    side_light_o = LAMP_R;
    case (state_q)
      MAIN_G:  main_light_o = LAMP_G;
      MAIN_Y:  main_light_o = LAMP_Y;
      SIDE_G:  side_light_o = LAMP_G;
      SIDE_Y:  side_light_o = LAMP_Y;
      default: ;
    endcase
  end

  assign ped_walk_o    = walk_q;
  assign ped_pending_o = pend_q;
  assign phase_o       = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller: a behavioural model pushes expected
// outputs to a scoreboard queue per step; each is popped and compared after the edge.
module tb_intersection_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side = 1'b0;
  logic       ped = 1'b0;
  logic [2:0] main_light, side_light, phase;
  logic       ped_walk, ped_pending;

  int vectors = 0;
  int miscompares = 0;
  logic [10:0] sb_q[$];

  int   m_ph, m_cnt;
  logic m_pend, m_walk;
  logic [2:0] prev_main, prev_side;

  intersection_controller dut (
    .clk_i(clk), .rst_i(rst), .side_sensor_i(side), .ped_req_i(ped),
    .main_light_o(main_light), .side_light_o(side_light),
    .ped_walk_o(ped_walk), .ped_pending_o(ped_pending), .phase_o(phase)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int ph);
    case (ph)
      0:       return 8;
      1, 4:    return 3;
      3:       return 6;
      default: return 2;
    endcase
  endfunction

  function automatic logic [10:0] exp_vec(input int ph, input logic w, input logic p);
    logic [2:0] mn, sd;
    mn = 3'b100;
    sd = 3'b100;
    if (ph == 0) mn = 3'b010;
    if (ph == 1) mn = 3'b001;
    if (ph == 3) sd = 3'b010;
    if (ph == 4) sd = 3'b001;
    return {3'(ph), mn, sd, w, p};
  endfunction

  task automatic model_reset();
    m_ph = 5; m_cnt = 1; m_pend = 1'b0; m_walk = 1'b0;
  endtask

  // m_cnt counts cycles spent in the current phase, starting at 1 on entry.
  task automatic model_edge(input logic s, input logic p);
    int   nxt;
    logic done, npend, nwalk;
    nxt  = m_ph;
    done = (m_cnt >= dur(m_ph));
    if (m_ph == 0) begin
      if (done && (s || m_pend)) nxt = 1;
    end else if (done) begin
      nxt = (m_ph == 5) ? 0 : m_ph + 1;
    end
    npend = m_pend | p;
    nwalk = m_walk;
    if (nxt == 3 && m_ph != 3) begin
      nwalk = m_pend | p;
      npend = 1'b0;
    end else if (m_ph == 3 && nxt != 3) begin
      nwalk = 1'b0;
    end
    m_cnt  = (nxt != m_ph) ? 1 : m_cnt + 1;
    m_ph   = nxt;
    m_pend = npend;
    m_walk = nwalk;
  endtask

  task automatic compare(input string tag);
    logic [10:0] e, obs;
    obs = {phase, main_light, side_light, ped_walk, ped_pending};
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h (phase,main,side,walk,pend)", tag, obs, e);
      end
    end
  endtask

  task automatic check_inv(input string tag);
    logic ok;
    ok = (main_light == 3'b100 || side_light == 3'b100)
      && (!ped_walk || main_light == 3'b100)
      && !(prev_main == 3'b010 && main_light == 3'b100)
      && !(prev_side == 3'b010 && side_light == 3'b100);
    vectors++;
    assert (ok === 1'b1) else begin
      miscompares++;
      $error("FAIL %s_invariant observed main=%b side=%b walk=%b prev_main=%b prev_side=%b expected safe",
             tag, main_light, side_light, ped_walk, prev_main, prev_side);
    end
    prev_main = main_light;
    prev_side = side_light;
  endtask

  // Called 1 time unit after a rising edge; asserts reset mid-cycle and releases before the next edge.
  task automatic do_reset(input string tag);
    rst = 1'b1; side = 1'b0; ped = 1'b0;
    #2;
    model_reset();
    sb_q.push_back(exp_vec(m_ph, m_walk, m_pend));
    compare(tag);
    #2 rst = 1'b0;
    prev_main = 3'b100;
    prev_side = 3'b100;
  endtask

  task automatic step(input logic s, input logic p, input string tag);
    side = s;
    ped  = p;
    model_edge(s, p);
    sb_q.push_back(exp_vec(m_ph, m_walk, m_pend));
    @(posedge clk);
    #1;
    compare(tag);
    check_inv(tag);
  endtask

  initial begin
    #6;
    do_reset("reset_state");
    repeat (100) step(1'b0, 1'b0, "idle_main_green");

    do_reset("reset_b");
    repeat (3) step(1'b0, 1'b0, "to_main_green");
    step(1'b1, 1'b0, "side_pulse_early");
    repeat (30) step(1'b0, 1'b0, "side_pulse_ignored");

    do_reset("reset_c");
    repeat (3) step(1'b0, 1'b0, "to_main_green_ped");
    step(1'b0, 1'b1, "ped_pulse");
    for (int i = 0; i < 40 && m_ph != 3; i++) step(1'b0, 1'b0, "ped_to_side_g");
    step(1'b0, 1'b0, "walk_active");
    step(1'b0, 1'b1, "ped_during_walk");
    repeat (60) step(1'b0, 1'b0, "ped_next_round");

    do_reset("reset_d");
    repeat (72) step(1'b1, 1'b0, "side_continuous");

    for (int i = 0; i < 40 && !(m_ph == 3 && m_cnt == 3); i++) step(1'b1, 1'b0, "to_side_g_mid");
    do_reset("async_reset_mid_side_g");
    repeat (12) step(1'b0, 1'b0, "after_async_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
